// File: rtl/gray_conv_arb_pkg.sv
// Shared types and constants for the gray-code conversion arbiter.
// Optional feature macro: GRAY_CONV_ARB_B2G_EN (enables the binary-to-gray path).
package gray_conv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

endpackage

// File: rtl/gray_conv_arbiter_core.sv
// Combinational gray<->binary converter shared by all requesters.
// Optional feature macro: GRAY_CONV_ARB_B2G_EN (builds the binary-to-gray path).
module gray_conv_core
    import gray_conv_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             mode,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] g2b;

    // Gray-to-binary: each binary bit is the running XOR of gray bits from the MSB down
    always_comb begin : g2b_chain
        logic acc;
        acc = 1'b0;
        g2b = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            acc    = acc ^ operand[i];
            g2b[i] = acc;
        end
    end

`ifdef GRAY_CONV_ARB_B2G_EN
    logic [WIDTH-1:0] b2g;

    assign b2g    = operand ^ (operand >> 1);
    assign result = (mode == MODE_B2G) ? b2g : g2b;
`else
    // Direction input has no effect when only gray-to-binary is built
    logic unused_mode;

    assign unused_mode = (mode == MODE_B2G);
    assign result      = g2b;
`endif

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding a single shared gray-code converter (IDLE/CONV/HOLD).
// Optional feature macro: GRAY_CONV_ARB_B2G_EN (honour req_mode for binary-to-gray).
module gray_conv_arbiter
    import gray_conv_arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 3,
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    state_t            state;
    state_t            next_state;
    logic              any_req;
    logic [ID_W-1:0]   last_winner;
    logic [ID_W-1:0]   win_idx;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_mode;
    logic [WIDTH-1:0]  op_data;
    logic              op_mode;
    logic [ID_W-1:0]   op_id;
    logic [WIDTH-1:0]  result;

    assign any_req   = |req;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // Round-robin search starting just after the previous winner
    always_comb begin : rr_search
        logic [ID_W-1:0] cand;
        logic            found;
        cand    = '0;
        found   = 1'b0;
        win_idx = last_winner;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = ID_W'((int'(last_winner) + k) % int'(NREQ));
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    // Operand and direction of the current winner
    always_comb begin
        sel_data = '0;
        sel_mode = MODE_G2B;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ID_W'(i) == win_idx) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
                sel_mode = req_mode[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and grant pulse; grant is suppressed while reset is held
    always_comb begin
        next_state = state;
        gnt        = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = CONV;
                    if (!rst) begin
                        gnt = NREQ'(1) << win_idx;
                    end
                end
            end
            CONV: next_state = HOLD;
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifndef GRAY_CONV_ARB_B2G_EN
    logic unused_sel_mode;

    assign unused_sel_mode = sel_mode;
`endif

    // Operand capture on grant, result capture on leaving CONV
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= ID_W'(NREQ - 1);
            op_data     <= '0;
            op_mode     <= MODE_G2B;
            op_id       <= '0;
            out_data    <= '0;
            out_id      <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_winner <= win_idx;
                op_data     <= sel_data;
                op_id       <= win_idx;
`ifdef GRAY_CONV_ARB_B2G_EN
                op_mode     <= sel_mode;
`else
                op_mode     <= MODE_G2B;
`endif
            end
            if (state == CONV) begin
                out_data <= result;
                out_id   <= op_id;
            end
        end
    end

    gray_conv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .operand (op_data),
        .mode    (op_mode),
        .result  (result)
    );

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter with a transaction-level reference model.
// Honours GRAY_CONV_ARB_B2G_EN for the expected binary-to-gray results.
module tb_gray_conv_arbiter;

    localparam int WIDTH = 3;
    localparam int NREQ  = 4;
    localparam int MASK  = (1 << WIDTH) - 1;
`ifdef GRAY_CONV_ARB_B2G_EN
    localparam bit B2G = 1'b1;
`else
    localparam bit B2G = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       req_mode = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic                  out_ready = 1'b1;
    logic [NREQ-1:0]       gnt;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_id;
    logic                  busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // reference model state: phase 0 waiting, 1 converting, 2 presenting
    int m_phase = 0;
    int m_last = NREQ - 1;
    int m_res = 0;
    int m_res_id = 0;
    int m_out_data = 0;
    int m_out_id = 0;

    gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail_timeout(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] r, int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return last;
    endfunction

    // prefix XOR by doubling shifts
    function automatic int g2b(int g);
        int b;
        b = g;
        for (int s = 1; s < WIDTH; s = s * 2) b = b ^ (b >> s);
        return b & MASK;
    endfunction

    function automatic int conv(int d, int m);
        if (B2G && m != 0) return (d ^ (d >> 1)) & MASK;
        return g2b(d);
    endfunction

    // transaction-level reference model
    always @(posedge clk or posedge rst) begin : model
        int w;
        if (rst) begin
            m_phase    <= 0;
            m_last     <= NREQ - 1;
            m_out_data <= 0;
            m_out_id   <= 0;
        end else begin
            case (m_phase)
                0: if (req != 0) begin
                    w = rr_pick(req, m_last);
                    m_last   <= w;
                    m_res    <= conv(int'(req_data >> (w * WIDTH)) & MASK, int'(req_mode[w]));
                    m_res_id <= w;
                    m_phase  <= 1;
                end
                1: begin
                    m_out_data <= m_res;
                    m_out_id   <= m_res_id;
                    m_phase    <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        int eg;
        if (chk_en) begin
            eg = (m_phase == 0 && req != 0 && !rst) ? (1 << rr_pick(req, m_last)) : 0;
            check("cyc_gnt", int'(gnt), eg);
            check("cyc_out_valid", int'(out_valid), (m_phase == 2) ? 1 : 0);
            check("cyc_busy", int'(busy), (m_phase != 0) ? 1 : 0);
            check("cyc_out_data", int'(out_data), m_out_data);
            check("cyc_out_id", int'(out_id), m_out_id);
        end
    end

    task automatic drain(string nm);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) fail_timeout(nm);
    endtask

    task automatic wait_gnt(string nm, output bit got);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (gnt != 0) got = 1'b1;
        end
        if (!got) fail_timeout(nm);
    endtask

    task automatic run_one(input int id, input logic mode, input logic [WIDTH-1:0] data,
                           input int exp, input string nm);
        bit got;
        int lat;
        @(posedge clk); #1;
        req = NREQ'(1) << id;
        req_mode[id] = mode;
        req_data[id*WIDTH +: WIDTH] = data;
        wait_gnt({nm, "_gnt_wait"}, got);
        if (got) check({nm, "_gnt"}, int'(gnt), 1 << id);
        @(posedge clk); #1;
        req = '0;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        if (!got) begin
            fail_timeout({nm, "_valid_wait"});
        end else begin
            check({nm, "_latency"}, lat, 2);
            check({nm, "_out_data"}, int'(out_data), exp);
            check({nm, "_out_id"}, int'(out_id), id);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int sweep_exp[8];
        int rr_exp[5];
        int ids[$];
        int stamps[$];
        bit got;
        int saved;

        sweep_exp = '{0, 1, 3, 2, 7, 6, 4, 5};
        rr_exp    = '{0, 1, 2, 3, 0};

        // reset with all requests pending: nothing may be granted
        #1 rst = 1'b1;
        chk_en = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req = '0;

        run_one(0, 1'b0, 3'b111, 3'b101, "s1_g2b");
        run_one(2, 1'b1, 3'b110, B2G ? 3'b101 : 3'b100, "s2_mode1");
        for (int g = 0; g < 8; g++) begin
            run_one(3, 1'b0, 3'(g), sweep_exp[g], $sformatf("sweep_g%0d", g));
        end

        // all requesters held: round-robin order and 3-cycle spacing
        @(posedge clk); #1;
        req = 4'b1111;
        for (int c = 0; c < 40 && ids.size() < 5; c++) begin
            @(negedge clk);
            if (gnt != 0) begin
                ids.push_back($clog2(gnt));
                stamps.push_back(cyc);
            end
        end
        @(posedge clk); #1;
        req = '0;
        if (ids.size() < 5) begin
            fail_timeout("rr_grants");
        end else begin
            for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), ids[i], rr_exp[i]);
            for (int i = 1; i < 5; i++) check($sformatf("rr_gap%0d", i), stamps[i] - stamps[i-1], 3);
        end
        drain("rr_drain");

        // back-pressure in HOLD with another requester waiting
        @(posedge clk); #1;
        out_ready = 1'b0;
        req = 4'b0010;
        req_mode[1] = 1'b0;
        req_data[1*WIDTH +: WIDTH] = 3'b011;
        wait_gnt("bp_gnt_wait", got);
        if (got) check("bp_gnt", int'(gnt), 4'b0010);
        @(posedge clk); #1;
        req = 4'b0100;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        if (!got) fail_timeout("bp_valid_wait");
        saved = int'(out_data);
        check("bp_out_data", saved, 3'b010);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_data", int'(out_data), saved);
            check("bp_hold_gnt", int'(gnt), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(out_valid), 1);
        @(negedge clk);
        check("bp_idle_busy", int'(busy), 0);
        check("bp_rearb_gnt", int'(gnt), 4'b0100);
        @(posedge clk); #1;
        req = '0;
        drain("bp_drain");

        // reset in the middle of a conversion
        @(posedge clk); #1;
        req = 4'b0010;
        wait_gnt("mid_gnt_wait", got);
        if (got) check("mid_gnt", int'(gnt), 4'b0010);
        @(posedge clk); #1;
        check("mid_busy_conv", int'(busy), 1);
        rst = 1'b1;
        req = '0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("mid_no_result", int'(out_valid), 0);
        end
        @(posedge clk); #1;
        req = 4'b1111;
        wait_gnt("mid_first_wait", got);
        if (got) check("mid_first_gnt", int'(gnt), 4'b0001);
        @(posedge clk); #1;
        req = '0;
        drain("mid_drain");

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
